// File: rtl/cache_control_if.sv
// CPU, datapath and physical-memory signals of the L1 cache controller.
// The master side drives requests and datapath status; the slave side is the controller.
interface cache_control_if #(
  parameter int s_offset = 5
);
  localparam int s_mask = 2**s_offset;

  logic              mem_read;
  logic              mem_write;
  logic [3:0]        mem_byte_enable;
  logic [31:0]       mem_address;
  logic              mem_resp;
  logic [1:0]        hit;
  logic [1:0]        dirty;
  logic              pmem_read;
  logic              pmem_write;
  logic              pmem_resp;
  logic              pmem_addr_sel;
  logic              data_src;
  logic [s_mask-1:0] data_we0;
  logic [s_mask-1:0] data_we1;
  logic [1:0]        tag_we;
  logic [1:0]        valid_set;
  logic [1:0]        dirty_set;
  logic [1:0]        dirty_clr;
  logic              rd_way;
  logic [15:0]       miss_count;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, hit, dirty, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_src, data_we0, data_we1,
           tag_we, valid_set, dirty_set, dirty_clr, rd_way, miss_count
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, hit, dirty, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_src, data_we0, data_we1,
           tag_we, valid_set, dirty_set, dirty_clr, rd_way, miss_count
  );
endinterface

// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative L1 cache: hit/miss resolution, dirty
// writeback, line allocation, per-set LRU and a saturating miss counter.
module cache_control #(
  parameter int          s_offset = 5,
  parameter int          s_index  = 3,
  parameter logic [15:0] miss_max = 16'hFFFF
) (
  input logic            clk,
  input logic            rst,
  cache_control_if.slave bus
);
  localparam int s_mask   = 2**s_offset;
  localparam int num_sets = 2**s_index;

  typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;

  state_t              state_q, state_d;
  logic                victim_q, victim_d;
  logic [num_sets-1:0] lru_q;
  logic [15:0]         miss_q;
  logic [s_index-1:0]  index;
  logic [s_offset-3:0] word;
  logic                req;
  logic                any_hit;
  logic                hit_way;
  logic                miss;
  logic [s_mask-1:0]   be_mask;

  assign index   = bus.mem_address[s_offset+s_index-1:s_offset];
  assign word    = bus.mem_address[s_offset-1:2];
  assign req     = bus.mem_read | bus.mem_write;
  assign any_hit = |bus.hit;
  // An illegal double hit resolves to way 0.
  assign hit_way = ~bus.hit[0];
  assign miss    = (state_q == CHECK) && req && !any_hit;
  assign be_mask = s_mask'(bus.mem_byte_enable) << {word, 2'b00};

  assign bus.miss_count = miss_q;

  // NOTE: the LRU bits are a handful of flops, not a RAM macro, so they take the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CHECK;
      victim_q <= 1'b0;
      lru_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if ((state_q == CHECK) && req && any_hit) lru_q[index] <= ~hit_way;
      if (miss && (miss_q != miss_max)) miss_q <= miss_q + 16'd1;
    end
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d           = state_q;
    victim_d          = victim_q;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.data_src      = 1'b0;
    bus.data_we0      = '0;
    bus.data_we1      = '0;
    bus.tag_we        = 2'b00;
    bus.valid_set     = 2'b00;
    bus.dirty_set     = 2'b00;
    bus.dirty_clr     = 2'b00;
    bus.rd_way        = 1'b0;

    unique case (state_q)
      CHECK: begin
        if (req && any_hit) begin
          bus.mem_resp = 1'b1;
          bus.rd_way   = hit_way;
          if (bus.mem_write) begin
            if (hit_way) bus.data_we1 = be_mask;
            else         bus.data_we0 = be_mask;
            bus.dirty_set[hit_way] = 1'b1;
          end
        end else if (req) begin
          victim_d = lru_q[index];
          state_d  = bus.dirty[lru_q[index]] ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        bus.rd_way        = victim_q;
        if (bus.pmem_resp) begin
          bus.dirty_clr[victim_q] = 1'b1;
          // A request abandoned during writeback skips the refill.
          state_d = req ? ALLOCATE : CHECK;
        end
      end

      ALLOCATE: begin
        bus.pmem_read = 1'b1;
        bus.data_src  = 1'b1;
        if (bus.pmem_resp) begin
          if (victim_q) bus.data_we1 = '1;
          else          bus.data_we0 = '1;
          bus.tag_we[victim_q]    = 1'b1;
          bus.valid_set[victim_q] = 1'b1;
          bus.dirty_clr[victim_q] = 1'b1;
          state_d                 = CHECK;
        end
      end

      default: state_d = CHECK;
    endcase
  end
endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: a per-cycle vector table for the main flows,
// plus hand-written sequences for reset during writeback and counter saturation.
module tb_cache_control;
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [1:0]  hit;
    logic [1:0]  dirty;
    logic        presp;
  } in_t;

  typedef struct packed {
    logic        resp;
    logic        pr;
    logic        pw;
    logic        sel;
    logic        src;
    logic [31:0] we0;
    logic [31:0] we1;
    logic [1:0]  tag;
    logic [1:0]  vs;
    logic [1:0]  ds;
    logic [1:0]  dc;
    logic        rw;
    logic [15:0] mc;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;
  localparam logic [31:0] Z   = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  cache_control_if #(.s_offset(5)) bus ();
  cache_control_if #(.s_offset(5)) bus2 ();

  cache_control dut (.clk(clk), .rst(rst), .bus(bus));
  cache_control #(.miss_max(16'd20)) dut_sat (.clk(clk), .rst(rst2), .bus(bus2));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel, bus.data_src,
         bus.data_we0, bus.data_we1, bus.tag_we, bus.valid_set, bus.dirty_set,
         bus.dirty_clr, bus.rd_way, bus.miss_count};
    return o;
  endfunction

  task automatic apply(input in_t i);
    bus.mem_read        = i.rd;
    bus.mem_write       = i.wr;
    bus.mem_byte_enable = i.be;
    bus.mem_address     = i.addr;
    bus.hit             = i.hit;
    bus.dirty           = i.dirty;
    bus.pmem_resp       = i.presp;
  endtask

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    out_t o;

    // {rd,wr,be,addr,hit,dirty,presp} -> {resp,pr,pw,sel,src,we0,we1,tag,vs,ds,dc,rw,mc}
    // Idle, then clean read miss at 0x40 (set 2, victim way 0) and retry hit.
    add({1'b0,1'b0,4'h0,32'h00,2'b00,2'b00,1'b0}, {1'b0,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd0});
    add({1'b1,1'b0,4'h0,32'h40,2'b00,2'b00,1'b0}, {1'b0,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd0});
    add({1'b1,1'b0,4'h0,32'h40,2'b00,2'b00,1'b0}, {1'b0,1'b1,1'b0,1'b0,1'b1,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd1});
    add({1'b1,1'b0,4'h0,32'h40,2'b00,2'b00,1'b1}, {1'b0,1'b1,1'b0,1'b0,1'b1,ALL,Z,2'b01,2'b01,2'b00,2'b01,1'b0,16'd1});
    add({1'b1,1'b0,4'h0,32'h40,2'b01,2'b00,1'b0}, {1'b1,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd1});
    // Write hit way 1, word 3, be 0011.
    add({1'b0,1'b1,4'h3,32'h0C,2'b10,2'b00,1'b0}, {1'b1,1'b0,1'b0,1'b0,1'b0,Z,32'h3000,2'b00,2'b00,2'b10,2'b00,1'b1,16'd1});
    // Dirty miss at set 2 (lru=1): writeback way 1, then refill way 1.
    add({1'b1,1'b0,4'h0,32'h40,2'b00,2'b10,1'b0}, {1'b0,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd1});
    add({1'b1,1'b0,4'h0,32'h40,2'b00,2'b10,1'b0}, {1'b0,1'b0,1'b1,1'b1,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b1,16'd2});
    add({1'b1,1'b0,4'h0,32'h40,2'b00,2'b10,1'b1}, {1'b0,1'b0,1'b1,1'b1,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b10,1'b1,16'd2});
    add({1'b1,1'b0,4'h0,32'h40,2'b00,2'b10,1'b0}, {1'b0,1'b1,1'b0,1'b0,1'b1,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd2});
    add({1'b1,1'b0,4'h0,32'h40,2'b00,2'b10,1'b1}, {1'b0,1'b1,1'b0,1'b0,1'b1,Z,ALL,2'b10,2'b10,2'b00,2'b10,1'b0,16'd2});
    add({1'b1,1'b0,4'h0,32'h40,2'b10,2'b00,1'b0}, {1'b1,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b1,16'd2});
    // LRU alternation in set 1: hit way 0 -> victim way 1; hit way 1 -> victim way 0.
    add({1'b0,1'b1,4'hF,32'h24,2'b01,2'b00,1'b0}, {1'b1,1'b0,1'b0,1'b0,1'b0,32'hF0,Z,2'b00,2'b00,2'b01,2'b00,1'b0,16'd2});
    add({1'b1,1'b0,4'h0,32'h20,2'b00,2'b01,1'b0}, {1'b0,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd2});
    add({1'b1,1'b0,4'h0,32'h20,2'b00,2'b01,1'b1}, {1'b0,1'b1,1'b0,1'b0,1'b1,Z,ALL,2'b10,2'b10,2'b00,2'b10,1'b0,16'd3});
    add({1'b1,1'b0,4'h0,32'h20,2'b10,2'b00,1'b0}, {1'b1,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b1,16'd3});
    add({1'b1,1'b0,4'h0,32'h20,2'b00,2'b11,1'b0}, {1'b0,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd3});
    add({1'b1,1'b0,4'h0,32'h20,2'b00,2'b11,1'b1}, {1'b0,1'b0,1'b1,1'b1,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b01,1'b0,16'd4});
    add({1'b1,1'b0,4'h0,32'h20,2'b00,2'b00,1'b1}, {1'b0,1'b1,1'b0,1'b0,1'b1,ALL,Z,2'b01,2'b01,2'b00,2'b01,1'b0,16'd4});
    add({1'b1,1'b0,4'h0,32'h20,2'b01,2'b00,1'b0}, {1'b1,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd4});
    // Read+write together with illegal hit=11: write to way 0, word 7, be 1000.
    add({1'b1,1'b1,4'h8,32'h1C,2'b11,2'b00,1'b0}, {1'b1,1'b0,1'b0,1'b0,1'b0,32'h8000_0000,Z,2'b00,2'b00,2'b01,2'b00,1'b0,16'd4});
    // Request dropped during writeback of set 3: finish, return to CHECK, no response.
    add({1'b1,1'b0,4'h0,32'h60,2'b00,2'b01,1'b0}, {1'b0,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd4});
    add({1'b0,1'b0,4'h0,32'h60,2'b00,2'b01,1'b0}, {1'b0,1'b0,1'b1,1'b1,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd5});
    add({1'b0,1'b0,4'h0,32'h60,2'b00,2'b01,1'b1}, {1'b0,1'b0,1'b1,1'b1,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b01,1'b0,16'd5});
    add({1'b0,1'b0,4'h0,32'h60,2'b00,2'b00,1'b0}, {1'b0,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd5});

    apply('0);
    bus2.mem_read        = 1'b1;
    bus2.mem_write       = 1'b0;
    bus2.mem_byte_enable = 4'h0;
    bus2.mem_address     = 32'h0;
    bus2.hit             = 2'b00;
    bus2.dirty           = 2'b00;
    bus2.pmem_resp       = 1'b1;

    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      apply(vecs[k].i);
      #1;
      o = sample();
      check($sformatf("vec%0d", k), 128'(o), 128'(vecs[k].o));
    end

    // Reset asserted mid-writeback (set 4, victim way 0 dirty).
    @(negedge clk);
    apply({1'b1,1'b0,4'h0,32'h80,2'b00,2'b01,1'b0});
    @(negedge clk);
    #1;
    check("wb_pmem_write", 128'(bus.pmem_write), 128'(1'b1));
    #2 rst = 1'b1;
    #1;
    o = sample();
    check("rst_mid_wb", 128'(o), 128'(out_t'({1'b0,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd0})));
    @(negedge clk);
    rst = 1'b0;
    apply({1'b1,1'b0,4'h0,32'h80,2'b01,2'b00,1'b0});
    #1;
    o = sample();
    check("post_rst_hit", 128'(o), 128'(out_t'({1'b1,1'b0,1'b0,1'b0,1'b0,Z,Z,2'b00,2'b00,2'b00,2'b00,1'b0,16'd0})));

    // Saturating miss counter: back-to-back misses, two cycles each, ceiling 20.
    @(negedge clk);
    apply('0);
    rst2 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("miss_count_10cyc", 128'(bus2.miss_count), 128'(16'd5));
    repeat (40) @(posedge clk);
    #1;
    check("miss_count_sat", 128'(bus2.miss_count), 128'(16'd20));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
